// File: rtl/ex_mem_stage.sv
// Execute stage with the EX/MEM pipeline register. It covers operand forwarding,
// ALU control decode, the ALU, the branch target adder and the registered EX/MEM bundle.
module ex_mem_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              valid_in,
   input  logic [1:0]        wb_in,
   input  logic [2:0]        mem_in,
   input  logic [1:0]        alu_op,
   input  logic              alu_src,
   input  logic              reg_dst,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [DATA_W-1:0] reg1_in,
   input  logic [DATA_W-1:0] reg2_in,
   input  logic [DATA_W-1:0] offset_in,
   input  logic [REG_AW-1:0] rt_in,
   input  logic [REG_AW-1:0] rd_in,
   input  logic [1:0]        forward_a,
   input  logic [1:0]        forward_b,
   input  logic [DATA_W-1:0] wb_data,
   output logic [1:0]        wb_out,
   output logic [2:0]        mem_out,
   output logic [DATA_W-1:0] alu_result_out,
   output logic              zero_out,
   output logic [DATA_W-1:0] branch_target_out,
   output logic [DATA_W-1:0] store_data_out,
   output logic [REG_AW-1:0] dest_reg_out,
   output logic              valid_out
);

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_ctrl_e;

   logic [1:0]        wb_q;
   logic [2:0]        mem_q;
   logic [DATA_W-1:0] alu_result_q;
   logic              zero_q;
   logic [DATA_W-1:0] branch_target_q;
   logic [DATA_W-1:0] store_data_q;
   logic [REG_AW-1:0] dest_reg_q;
   logic              valid_q;

   logic [1:0]        wb_d;
   logic [2:0]        mem_d;
   logic [DATA_W-1:0] alu_result_d;
   logic              zero_d;
   logic [DATA_W-1:0] branch_target_d;
   logic [DATA_W-1:0] store_data_d;
   logic [REG_AW-1:0] dest_reg_d;

   logic [DATA_W-1:0] operand_a;
   logic [DATA_W-1:0] fwd_b;
   logic [DATA_W-1:0] operand_b;
   alu_ctrl_e         alu_ctrl;

   // Code 10 feeds back the EX/MEM result, which a stall leaves untouched.
   always_comb begin
      operand_a = reg1_in;
      case (forward_a)
         2'b01:   operand_a = wb_data;
         2'b10:   operand_a = alu_result_q;
         default: operand_a = reg1_in;
      endcase
      fwd_b = reg2_in;
      case (forward_b)
         2'b01:   fwd_b = wb_data;
         2'b10:   fwd_b = alu_result_q;
         default: fwd_b = reg2_in;
      endcase
      operand_b = alu_src ? offset_in : fwd_b;
   end

   always_comb begin
      alu_ctrl = ALU_ADD;
      case (alu_op)
         2'b01: alu_ctrl = ALU_SUB;
         2'b10: begin
            case (offset_in[5:0])
               6'b100010: alu_ctrl = ALU_SUB;
               6'b100100: alu_ctrl = ALU_AND;
               6'b100101: alu_ctrl = ALU_OR;
               6'b101010: alu_ctrl = ALU_SLT;
               default:   alu_ctrl = ALU_ADD;
            endcase
         end
         default: alu_ctrl = ALU_ADD;
      endcase
   end

   always_comb begin
      alu_result_d = operand_a + operand_b;
      case (alu_ctrl)
         ALU_SUB: alu_result_d = operand_a - operand_b;
         ALU_AND: alu_result_d = operand_a & operand_b;
         ALU_OR:  alu_result_d = operand_a | operand_b;
         ALU_SLT: alu_result_d = {{(DATA_W-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
         default: alu_result_d = operand_a + operand_b;
      endcase
      zero_d          = (alu_result_d == '0);
      branch_target_d = pc_in + {offset_in[DATA_W-3:0], 2'b00};
      store_data_d    = fwd_b;
      dest_reg_d      = reg_dst ? rd_in : rt_in;
      // A non-instruction must never write the register file or memory.
      wb_d            = valid_in ? wb_in : 2'b00;
      mem_d           = valid_in ? mem_in : 3'b000;
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wb_q            <= '0;
         mem_q           <= '0;
         alu_result_q    <= '0;
         zero_q          <= 1'b0;
         branch_target_q <= '0;
         store_data_q    <= '0;
         dest_reg_q      <= '0;
         valid_q         <= 1'b0;
      end else if (!stall) begin
         wb_q            <= wb_d;
         mem_q           <= mem_d;
         alu_result_q    <= alu_result_d;
         zero_q          <= zero_d;
         branch_target_q <= branch_target_d;
         store_data_q    <= store_data_d;
         dest_reg_q      <= dest_reg_d;
         valid_q         <= valid_in;
      end
   end

   assign wb_out            = wb_q;
   assign mem_out           = mem_q;
   assign alu_result_out    = alu_result_q;
   assign zero_out          = zero_q;
   assign branch_target_out = branch_target_q;
   assign store_data_out    = store_data_q;
   assign dest_reg_out      = dest_reg_q;
   assign valid_out         = valid_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed-vector bench for ex_mem_stage; expected values are hand-computed constants.
module tb_ex_mem_stage;

   logic        clock = 1'b0;
   logic        reset, stall, flush, valid_in, alu_src, reg_dst;
   logic [1:0]  wb_in, alu_op, forward_a, forward_b;
   logic [2:0]  mem_in;
   logic [31:0] pc_in, reg1_in, reg2_in, offset_in, wb_data;
   logic [4:0]  rt_in, rd_in;
   logic [1:0]  wb_out;
   logic [2:0]  mem_out;
   logic [31:0] alu_result_out, branch_target_out, store_data_out;
   logic        zero_out, valid_out;
   logic [4:0]  dest_reg_out;

   int n_cmp = 0;
   int n_err = 0;

   ex_mem_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
      .wb_in(wb_in), .mem_in(mem_in), .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst),
      .pc_in(pc_in), .reg1_in(reg1_in), .reg2_in(reg2_in), .offset_in(offset_in),
      .rt_in(rt_in), .rd_in(rd_in), .forward_a(forward_a), .forward_b(forward_b),
      .wb_data(wb_data), .wb_out(wb_out), .mem_out(mem_out), .alu_result_out(alu_result_out),
      .zero_out(zero_out), .branch_target_out(branch_target_out),
      .store_data_out(store_data_out), .dest_reg_out(dest_reg_out), .valid_out(valid_out)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [1:0] wb, input logic [2:0] mem,
                             input logic [31:0] alu, input logic zero, input logic [31:0] bt,
                             input logic [31:0] sd, input logic [4:0] dest, input logic vld);
      $display("txn %s: wb=%b mem=%b alu=%08h z=%b bt=%08h sd=%08h dest=%0d v=%b",
               tag, wb_out, mem_out, alu_result_out, zero_out, branch_target_out,
               store_data_out, dest_reg_out, valid_out);
      check({tag, ".wb"},    32'(wb_out), 32'(wb));
      check({tag, ".mem"},   32'(mem_out), 32'(mem));
      check({tag, ".alu"},   alu_result_out, alu);
      check({tag, ".zero"},  32'(zero_out), 32'(zero));
      check({tag, ".bt"},    branch_target_out, bt);
      check({tag, ".sd"},    store_data_out, sd);
      check({tag, ".dest"},  32'(dest_reg_out), 32'(dest));
      check({tag, ".valid"}, 32'(valid_out), 32'(vld));
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_in();
      stall = 0; flush = 0; valid_in = 0; alu_src = 0; reg_dst = 0;
      wb_in = 0; mem_in = 0; alu_op = 0; forward_a = 0; forward_b = 0;
      pc_in = 0; reg1_in = 0; reg2_in = 0; offset_in = 0; wb_data = 0;
      rt_in = 0; rd_in = 0;
   endtask

   task automatic alu_vec(input string tag, input logic [1:0] op, input logic [31:0] off,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      clear_in();
      valid_in = 1; alu_op = op; offset_in = off; reg1_in = a; reg2_in = b;
      step();
      $display("txn %s: alu=%08h", tag, alu_result_out);
      check({tag, ".alu"}, alu_result_out, exp);
   endtask

   initial begin
      clear_in();
      reset = 1;
      for (int i = 0; i < 2; i++) begin
         {wb_in, mem_in, alu_op, forward_a, forward_b} = 11'($urandom);
         {valid_in, alu_src, reg_dst, stall, flush} = 5'($urandom);
         pc_in = $urandom; reg1_in = $urandom; reg2_in = $urandom;
         offset_in = $urandom; wb_data = $urandom;
         rt_in = 5'($urandom); rd_in = 5'($urandom);
         step();
      end
      expect_out("reset", 2'b00, 3'b000, 0, 0, 0, 0, 0, 0);
      reset = 0;

      clear_in();
      valid_in = 1; wb_in = 2'b10; alu_op = 2'b10; offset_in = 32'h20;
      reg1_in = 5; reg2_in = 7; reg_dst = 1; rd_in = 3;
      step();
      expect_out("add", 2'b10, 3'b000, 12, 0, 32'h80, 7, 3, 1);

      clear_in();
      valid_in = 1; wb_in = 2'b11; mem_in = 3'b010; alu_op = 2'b00; alu_src = 1;
      pc_in = 32'h200; reg1_in = 32'h100; reg2_in = 32'hDEAD; offset_in = 32'hFFFF_FFFC;
      rt_in = 8; rd_in = 3;
      step();
      expect_out("lw", 2'b11, 3'b010, 32'hFC, 0, 32'h1F0, 32'hDEAD, 8, 1);

      clear_in();
      valid_in = 1; mem_in = 3'b100; alu_op = 2'b01; pc_in = 32'h40;
      reg1_in = 9; reg2_in = 9; offset_in = 3; rt_in = 8;
      step();
      expect_out("beq", 2'b00, 3'b100, 0, 1, 32'h4C, 9, 8, 1);

      alu_vec("slt_neg", 2'b10, 32'h2A, 32'hFFFF_FFFF, 32'h1, 32'h1);
      alu_vec("slt_pos", 2'b10, 32'h2A, 32'h1, 32'hFFFF_FFFF, 32'h0);
      alu_vec("and", 2'b10, 32'h24, 32'hF0F0, 32'hFF00, 32'hF000);
      alu_vec("or", 2'b10, 32'h25, 32'hF0F0, 32'hFF00, 32'hFFF0);
      alu_vec("sub_f", 2'b10, 32'h22, 7, 5, 2);
      alu_vec("funct_other", 2'b10, 32'h3F, 7, 5, 12);
      alu_vec("op11", 2'b11, 32'h22, 7, 5, 12);
      alu_vec("wrap", 2'b00, 0, 32'hFFFF_FFFF, 32'h2, 32'h1);

      alu_vec("fwd_prep", 2'b00, 0, 10, 12, 22);
      clear_in();
      valid_in = 1; wb_in = 2'b10; alu_op = 2'b01; forward_a = 2'b01; wb_data = 20;
      forward_b = 2'b10; reg1_in = 32'h111; reg2_in = 32'h222; reg_dst = 1; rd_in = 4;
      step();
      expect_out("fwd_sub", 2'b10, 3'b000, 32'hFFFF_FFFE, 0, 0, 22, 4, 1);

      clear_in();
      stall = 1; valid_in = 1; wb_in = 2'b11; mem_in = 3'b111; pc_in = 32'h1000;
      reg1_in = 99; reg2_in = 1; reg_dst = 1; rd_in = 17;
      for (int i = 0; i < 3; i++) begin
         reg1_in = reg1_in + 32'(i);
         step();
         check("stall.alu", alu_result_out, 32'hFFFF_FFFE);
      end
      expect_out("stall", 2'b10, 3'b000, 32'hFFFF_FFFE, 0, 0, 22, 4, 1);

      clear_in();
      valid_in = 1; forward_a = 2'b10; reg1_in = 55; reg2_in = 2;
      step();
      expect_out("fwd_after_stall", 2'b00, 3'b000, 0, 1, 0, 2, 0, 1);

      clear_in();
      valid_in = 1; forward_a = 2'b11; reg1_in = 32'h30; reg2_in = 4; wb_data = 32'h999;
      step();
      check("fwd11.alu", alu_result_out, 32'h34);

      clear_in();
      valid_in = 1; wb_in = 2'b11; mem_in = 3'b010; reg1_in = 1; rd_in = 6; reg_dst = 1;
      step();
      check("pre_flush.valid", 32'(valid_out), 1);
      stall = 1; flush = 1;
      step();
      expect_out("flush_stall", 2'b00, 3'b000, 0, 0, 0, 0, 0, 0);

      clear_in();
      valid_in = 0; wb_in = 2'b11; mem_in = 3'b001; reg1_in = 3; reg2_in = 4;
      step();
      expect_out("invalid", 2'b00, 3'b000, 7, 0, 0, 4, 0, 0);

      clear_in();
      valid_in = 1; wb_in = 2'b11; mem_in = 3'b001; reg1_in = 3; reg2_in = 4;
      reg_dst = 1; rd_in = 5;
      step();
      check("pre_reset.dest", 32'(dest_reg_out), 5);
      stall = 1; reset = 1;
      step();
      expect_out("reset_stall", 2'b00, 3'b000, 0, 0, 0, 0, 0, 0);
      reset = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Execute stage and EX/MEM pipeline register. It consumes the registered ID/EX bundle (WB/MEM control, ALUop, ALUSrc, RegDst, PC+4, operands, sign-extended offset, rt/rd). It applies forwarding, decodes ALU control, and computes the ALU result, zero flag and branch target. Results are registered into the EX/MEM bundle with stall, flush and valid tracking, feeding the MEM stage and the hazard unit.

Parameters:
DATA_W, 32, datapath width for operands, PC and results
REG_AW, 5, register index width

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold the EX/MEM register contents
flush  in  1  load a bubble into EX/MEM
valid_in  in  1  ID/EX entry holds a real instruction
wb_in  in  2  [1]=RegWrite, [0]=MemtoReg
mem_in  in  3  [2]=Branch, [1]=MemRead, [0]=MemWrite
alu_op  in  2  ALUop from ID/EX
alu_src  in  1  1: operand B = offset_in
reg_dst  in  1  1: dest = rd_in, 0: dest = rt_in
pc_in  in  32  PC+4 of the instruction
reg1_in  in  32  rs value
reg2_in  in  32  rt value
offset_in  in  32  sign-extended immediate; [5:0] = funct
rt_in  in  5  rt index
rd_in  in  5  rd index
forward_a  in  2  00 reg1_in, 01 wb_data, 10 alu_result_out, 11 reg1_in
forward_b  in  2  same encoding, applied to reg2_in
wb_data  in  32  MEM/WB write-back value
wb_out  out  2  registered wb_in
mem_out  out  3  registered mem_in
alu_result_out  out  32  registered ALU result
zero_out  out  1  registered (ALU result == 0)
branch_target_out  out  32  registered pc_in + (offset_in << 2)
store_data_out  out  32  registered forwarded B, before the ALUSrc mux
dest_reg_out  out  5  registered destination index
valid_out  out  1  registered valid

Behaviour:
- Operand A = forward_a mux. Forwarded B = forward_b mux. Operand B = alu_src ? offset_in : forwarded B.
- ALU control:
  - alu_op 00: add.
  - alu_op 01: sub.
  - alu_op 11: add (reserved).
  - alu_op 10: decode funct = offset_in[5:0] as 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 0/1). Any other funct gives add.
- Arithmetic wraps mod 2^32. No overflow detection.
- Branch target = pc_in + {offset_in[29:0], 2'b00}, mod 2^32.
- All outputs are combinational results registered at the rising edge, giving one-cycle latency.
- Update priority per edge: reset > flush > stall > load.
  - reset: every output is 0.
  - flush: wb_out=0, mem_out=0, valid_out=0. Data outputs (alu_result_out, zero_out, branch_target_out, store_data_out, dest_reg_out) are also 0.
  - stall (no flush): every output holds its value.
  - load: every output takes its new value. valid_out=valid_in.
- valid_in=0 on a load: wb_out and mem_out load as 0, valid_out=0, and data fields load normally.
- forward_a/forward_b=10 selects the current registered alu_result_out (EX/MEM forwarding). During a stall this value is unchanged.
- Reset mid-stall or mid-flush: reset wins. Outputs are 0 on the next edge.
- Flush and stall together: flush wins.

Test Plan:
- Reset=1 for 2 cycles with random inputs -> every output is 0. Release, then load add with reg1=5, reg2=7, alu_op=10, funct=100000, reg_dst=1, rd=3 -> next cycle alu_result_out=12, dest_reg_out=3, zero_out=0, valid_out=1.
- lw: alu_op=00, alu_src=1, reg1=0x100, offset=0xFFFFFFFC, wb_in=11, mem_in=010 -> alu_result_out=0xFC, dest_reg_out=rt, store_data_out=reg2_in.
- beq: alu_op=01, reg1=reg2=9, pc_in=0x40, offset=3, mem_in=100 -> zero_out=1, branch_target_out=0x4C. slt with -1 vs 1 -> alu_result_out=1.
- Forwarding: forward_a=01, wb_data=20, forward_b=10 with prior alu_result_out=22, sub -> alu_result_out=0xFFFFFFFE.
- Stall 3 cycles while inputs change -> outputs frozen. flush and stall asserted together -> wb_out=0, mem_out=0, valid_out=0.
- valid_in=0 with wb_in=11, mem_in=001 -> wb_out=0, mem_out=0, valid_out=0. Reset asserted during a stall -> all outputs 0 next edge.
